// File: rtl/bc_horner.sv
// Control block for Horner evaluation y = (A*x + B)*x + C on a shared mul/add unit.
// Moore FSM plus a wait counter that holds each multiply step for MUL_LAT cycles.
module bc_horner #(
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned CW      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       LX,
    output logic       RSTX,
    output logic       LH,
    output logic       RSTH,
    output logic       LS,
    output logic       Pronto,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        LOADX = 4'd1,
        MUL1  = 4'd2,
        ADD1  = 4'd3,
        MUL2  = 4'd4,
        ADD2  = 4'd5,
        STORE = 4'd6,
        DONE  = 4'd7,
        ABRT  = 4'd8
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(MUL_LAT - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            IDLE:  if (start && !abort) state_nx = LOADX;
            LOADX: state_nx = MUL1;
            MUL1: begin
                if (cnt == LAST) state_nx = ADD1;
                else             cnt_nx   = cnt + CW'(1);
            end
            ADD1:  state_nx = MUL2;
            MUL2: begin
                if (cnt == LAST) state_nx = ADD2;
                else             cnt_nx   = cnt + CW'(1);
            end
            ADD2:  state_nx = STORE;
            STORE: state_nx = DONE;
            DONE:  state_nx = start ? LOADX : IDLE;
            ABRT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort only acts on live evaluation states; ABRT itself always drains to IDLE.
        if (abort && (state inside {LOADX, MUL1, ADD1, MUL2, ADD2, STORE, DONE})) begin
            state_nx = ABRT;
            cnt_nx   = '0;
        end
    end

    always_comb begin
        M0     = 2'd0;
        M1     = 2'd0;
        M2     = 2'd0;
        LX     = 1'b0;
        RSTX   = 1'b0;
        LH     = 1'b0;
        RSTH   = 1'b0;
        LS     = 1'b0;
        Pronto = 1'b0;
        busy   = (state != IDLE);
        case (state)
            LOADX: begin
                LX   = 1'b1;
                RSTH = 1'b1;
            end
            MUL1: LH = (cnt == LAST);
            ADD1: begin
                M0 = 2'd1; M1 = 2'd3; M2 = 2'd2; LH = 1'b1;
            end
            MUL2: begin
                M1 = 2'd3; LH = (cnt == LAST);
            end
            ADD2: begin
                M0 = 2'd1; M1 = 2'd3; M2 = 2'd3; LH = 1'b1;
            end
            STORE: LS = 1'b1;
            DONE:  Pronto = 1'b1;
            ABRT: begin
                RSTX = 1'b1;
                RSTH = 1'b1;
            end
            default: ;
        endcase
        // Hold the datapath registers cleared for as long as reset is asserted.
        if (!rst_n) begin
            RSTX = 1'b1;
            RSTH = 1'b1;
        end
    end

endmodule
